// File: rtl/mod_arith_engine.sv
// -----------------------------------------------------------------------------
// mod_arith_engine
// Modular arithmetic engine: loads operands a, b and modulus p word-serially
// (LSB word first) over one DW-bit bus, computes a*b mod p (bit-serial
// interleaved, one multiplier bit per cycle), a+b mod p or a-b mod p, and
// unloads the N-bit result word-serially.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   din        load data word
//   load_a/b/p shift din into A/B/P (IDLE only, priority p > b > a)
//   mode       00 mul, 01 add, 10 sub, 11 reserved (sampled with start)
//   start      begin operation (IDLE only, ignored while any load flag is high)
//   unload     present the next result word on dout
//   dout       result word, LSB word first
//   dout_vld   dout holds a valid result word
//   busy       operation in progress (RUN and FIN)
//   done       one-cycle pulse: result register updated
//   err        sticky: p==0 or reserved mode at start; cleared by next start
// -----------------------------------------------------------------------------
module mod_arith_engine #(
    parameter int DW = 16,
    parameter int NW = 16,
    parameter int CW = 9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] din,
    input  logic          load_a,
    input  logic          load_b,
    input  logic          load_p,
    input  logic [1:0]    mode,
    input  logic          start,
    input  logic          unload,
    output logic [DW-1:0] dout,
    output logic          dout_vld,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam int N  = DW * NW;
    localparam int PW = (NW > 1) ? $clog2(NW) : 1;

    localparam logic [1:0]    MODE_MUL  = 2'b00;
    localparam logic [1:0]    MODE_ADD  = 2'b01;
    localparam logic [1:0]    MODE_SUB  = 2'b10;
    localparam logic [1:0]    MODE_RSVD = 2'b11;
    localparam logic [CW-1:0] CNT_LAST  = CW'(N - 1);
    localparam logic [PW-1:0] PTR_LAST  = PW'(NW - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FIN    = 2'd2,
        ST_UNLOAD = 2'd3
    } state_t;

    state_t state_r;
    state_t state_next_s;

    logic [N-1:0]  a_r;
    logic [N-1:0]  b_r;
    logic [N-1:0]  p_r;
    logic [N-1:0]  r_r;
    logic [CW-1:0] cnt_r;
    logic [PW-1:0] ptr_r;
    logic [1:0]    mode_r;
    logic [DW-1:0] dout_r;
    logic          dout_vld_r;
    logic          busy_r;
    logic          done_r;
    logic          err_r;

    logic          any_load_s;
    logic          start_ok_s;
    logic          bad_op_s;
    logic          unload_ok_s;
    logic          run_last_s;
    logic          a_bit_s;
    logic [N+1:0]  p_ext2_s;
    logic [N+1:0]  mul_t0_s;
    logic [N+1:0]  mul_t1_s;
    logic [N-1:0]  mul_res_s;
    logic [N:0]    p_ext1_s;
    logic [N:0]    add_t_s;
    logic [N-1:0]  add_res_s;
    logic [N:0]    sub_t_s;
    logic [N-1:0]  sub_res_s;
    logic [DW-1:0] word_s;

    // Control qualifiers: which requests are accepted in the current state
    always_comb begin
        any_load_s = load_a | load_b | load_p;
        start_ok_s = (state_r == ST_IDLE) && start && !any_load_s;
        bad_op_s   = (p_r == {N{1'b0}}) || (mode == MODE_RSVD);
        // start has priority over unload in IDLE
        if (state_r == ST_IDLE) begin
            unload_ok_s = unload && !start_ok_s;
        end else if (state_r == ST_UNLOAD) begin
            unload_ok_s = unload;
        end else begin
            unload_ok_s = 1'b0;
        end
        // add/sub finish after one RUN cycle, mul after the last multiplier bit
        run_last_s = (mode_r != MODE_MUL) || (cnt_r == {CW{1'b0}});
    end

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_ok_s) begin
                    if (bad_op_s) begin
                        state_next_s = ST_FIN;
                    end else begin
                        state_next_s = ST_RUN;
                    end
                end else if (unload) begin
                    state_next_s = ST_UNLOAD;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (run_last_s) begin
                    state_next_s = ST_FIN;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_FIN: begin
                state_next_s = ST_IDLE;
            end
            ST_UNLOAD: begin
                if (unload) begin
                    state_next_s = ST_UNLOAD;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Arithmetic datapath: one interleaved multiply step, modular add and sub
    always_comb begin
        // multiplier bit a[cnt], MSB first
        a_bit_s  = |(a_r & ({{(N-1){1'b0}}, 1'b1} << cnt_r));
        p_ext2_s = {2'b00, p_r};
        // 2R + B < 3P when R,B < P, so two conditional subtractions suffice
        if (a_bit_s) begin
            mul_t0_s = {1'b0, r_r, 1'b0} + {2'b00, b_r};
        end else begin
            mul_t0_s = {1'b0, r_r, 1'b0};
        end
        if (mul_t0_s >= p_ext2_s) begin
            mul_t1_s = mul_t0_s - p_ext2_s;
        end else begin
            mul_t1_s = mul_t0_s;
        end
        if (mul_t1_s >= p_ext2_s) begin
            mul_res_s = N'(mul_t1_s - p_ext2_s);
        end else begin
            mul_res_s = mul_t1_s[N-1:0];
        end

        p_ext1_s = {1'b0, p_r};
        add_t_s  = {1'b0, a_r} + {1'b0, b_r};
        if (add_t_s >= p_ext1_s) begin
            add_res_s = N'(add_t_s - p_ext1_s);
        end else begin
            add_res_s = add_t_s[N-1:0];
        end

        // bit N of the difference is the borrow
        sub_t_s = {1'b0, a_r} - {1'b0, b_r};
        if (sub_t_s[N]) begin
            sub_res_s = sub_t_s[N-1:0] + p_r;
        end else begin
            sub_res_s = sub_t_s[N-1:0];
        end
    end

    // Result word selected by the unload pointer
    always_comb begin
        word_s = {DW{1'b0}};
        for (int k = 0; k < NW; k++) begin
            word_s = word_s | ({DW{ptr_r == PW'(k)}} & r_r[k*DW +: DW]);
        end
    end

    // Operand registers: word-serial shift-in, IDLE only, priority P > B > A
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_r <= {N{1'b0}};
            b_r <= {N{1'b0}};
            p_r <= {N{1'b0}};
        end else if (state_r == ST_IDLE) begin
            if (load_p) begin
                p_r <= {din, p_r[N-1:DW]};
            end else if (load_b) begin
                b_r <= {din, b_r[N-1:DW]};
            end else if (load_a) begin
                a_r <= {din, a_r[N-1:DW]};
            end
        end
    end

    // Operation control: mode latch, error flag, bit counter and result
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_r <= MODE_MUL;
            err_r  <= 1'b0;
            cnt_r  <= {CW{1'b0}};
            r_r    <= {N{1'b0}};
        end else if (start_ok_s) begin
            mode_r <= mode;
            err_r  <= bad_op_s;
            cnt_r  <= CNT_LAST;
            r_r    <= {N{1'b0}};
        end else if (state_r == ST_RUN) begin
            case (mode_r)
                MODE_MUL: begin
                    r_r   <= mul_res_s;
                    cnt_r <= cnt_r - CW'(1);
                end
                MODE_ADD: begin
                    r_r <= add_res_s;
                end
                MODE_SUB: begin
                    r_r <= sub_res_s;
                end
                default: begin
                    r_r <= r_r;
                end
            endcase
        end
    end

    // Unload path: word pointer, output word and its valid flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_r      <= {PW{1'b0}};
            dout_r     <= {DW{1'b0}};
            dout_vld_r <= 1'b0;
        end else if (start_ok_s) begin
            ptr_r      <= {PW{1'b0}};
            dout_vld_r <= 1'b0;
        end else if (unload_ok_s) begin
            dout_r     <= word_s;
            dout_vld_r <= 1'b1;
            if (ptr_r == PTR_LAST) begin
                ptr_r <= {PW{1'b0}};
            end else begin
                ptr_r <= ptr_r + PW'(1);
            end
        end else begin
            dout_vld_r <= 1'b0;
        end
    end

    // State register; busy/done registered from the next state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s == ST_RUN) || (state_next_s == ST_FIN);
            done_r  <= (state_next_s == ST_FIN);
        end
    end

    assign dout     = dout_r;
    assign dout_vld = dout_vld_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign err      = err_r;

endmodule

// File: tb/tb_mod_arith_engine.sv
// -----------------------------------------------------------------------------
// tb_mod_arith_engine
// Drives a small instance (DW=4, NW=2) for the directed cases and a default
// instance (DW=16, NW=16) for the SM2 random sweep. The bench keeps its own
// arithmetic model (plain %, +, - on wide values) and a cycle-timing model of
// busy/done/err/dout; one negedge process compares the DUT against it.
// -----------------------------------------------------------------------------
module tb_mod_arith_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        sel;
    logic [15:0] g_din;
    logic        g_load_a, g_load_b, g_load_p, g_start, g_unload;
    logic [1:0]  g_mode;

    logic [3:0]  dout_s;
    logic        vld_s, busy_s, done_s, err_s;
    logic [15:0] dout_b;
    logic        vld_b, busy_b, done_b, err_b;

    logic [15:0] g_dout;
    logic        g_vld, g_busy, g_done, g_err;

    assign g_dout = sel ? dout_b : {12'h000, dout_s};
    assign g_vld  = sel ? vld_b  : vld_s;
    assign g_busy = sel ? busy_b : busy_s;
    assign g_done = sel ? done_b : done_s;
    assign g_err  = sel ? err_b  : err_s;

    mod_arith_engine #(.DW(4), .NW(2), .CW(4)) u_small (
        .clk(clk), .rst(rst), .din(g_din[3:0]),
        .load_a(g_load_a & ~sel), .load_b(g_load_b & ~sel), .load_p(g_load_p & ~sel),
        .mode(g_mode), .start(g_start & ~sel), .unload(g_unload & ~sel),
        .dout(dout_s), .dout_vld(vld_s), .busy(busy_s), .done(done_s), .err(err_s)
    );

    mod_arith_engine #(.DW(16), .NW(16), .CW(9)) u_big (
        .clk(clk), .rst(rst), .din(g_din),
        .load_a(g_load_a & sel), .load_b(g_load_b & sel), .load_p(g_load_p & sel),
        .mode(g_mode), .start(g_start & sel), .unload(g_unload & sel),
        .dout(dout_b), .dout_vld(vld_b), .busy(busy_b), .done(done_b), .err(err_b)
    );

    // model state
    logic [255:0] m_a, m_b, m_p, m_r;
    logic         exp_busy, exp_done, exp_err, exp_vld;
    logic [15:0]  exp_dout;
    int           exp_ptr;
    bit           chk_en;

    int n_chk = 0;
    int n_err = 0;

    localparam logic [255:0] SM2_P =
        256'hFFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_00000000_FFFFFFFF_FFFFFFFF;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int nw_f();
        return sel ? 16 : 2;
    endfunction

    function automatic int dw_f();
        return sel ? 16 : 4;
    endfunction

    function automatic logic [15:0] mask_f();
        return sel ? 16'hFFFF : 16'h000F;
    endfunction

    // Golden arithmetic straight from the definitions of the three operations
    function automatic logic [255:0] model_op(input logic [1:0] md, input logic [255:0] a,
                                              input logic [255:0] b, input logic [255:0] p);
        logic [511:0] prod;
        logic [256:0] s;
        if (p == 256'd0 || md == 2'b11) return 256'd0;
        case (md)
            2'b00: begin
                prod = ({256'd0, a} * {256'd0, b}) % {256'd0, p};
                return prod[255:0];
            end
            2'b01: begin
                s = ({1'b0, a} + {1'b0, b}) % {1'b0, p};
                return s[255:0];
            end
            default: begin
                if (a >= b) s = {1'b0, a - b};
                else        s = {1'b0, a} + {1'b0, p} - {1'b0, b};
                return s[255:0];
            end
        endcase
    endfunction

    function automatic logic [255:0] rand_below(input logic [255:0] p);
        logic [255:0] v;
        v = 256'd0;
        for (int j = 0; j < 8; j++) v = {v[223:0], 32'($urandom())};
        if (v >= p) v = v - p;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_model();
        m_a = 256'd0; m_b = 256'd0; m_p = 256'd0; m_r = 256'd0;
        exp_busy = 1'b0; exp_done = 1'b0; exp_err = 1'b0; exp_vld = 1'b0;
        exp_dout = 16'h0000; exp_ptr = 0;
    endtask

    task automatic reset_pulse();
        rst = 1'b0;
        reset_model();
        tick();
        rst = 1'b1;
        tick();
    endtask

    // flags = {load_p, load_b, load_a}; the register actually written follows p > b > a
    task automatic load_op(input logic [2:0] flags, input logic [255:0] val);
        for (int k = 0; k < nw_f(); k++) begin
            g_din = 16'(val >> (k * dw_f()));
            {g_load_p, g_load_b, g_load_a} = flags;
            tick();
        end
        {g_load_p, g_load_b, g_load_a} = 3'b000;
        if (flags[2])      m_p = val;
        else if (flags[1]) m_b = val;
        else if (flags[0]) m_a = val;
    endtask

    // Start an operation and walk the timing model: busy from the cycle after
    // start, done in the last busy cycle. rst_at>0 pulls reset at that cycle.
    task automatic run_op(input logic [1:0] md, input bit with_unload, input bit inject,
                          input int rst_at);
        int lat;
        bit bad;
        bit aborted;
        bad = (m_p == 256'd0) || (md == 2'b11);
        lat = bad ? 1 : ((md == 2'b00) ? nw_f() * dw_f() + 1 : 2);
        aborted = 1'b0;
        g_mode = md; g_start = 1'b1; g_unload = with_unload;
        tick();
        g_start = 1'b0; g_unload = 1'b0;
        exp_busy = 1'b1; exp_done = (lat == 1); exp_err = bad; exp_vld = 1'b0; exp_ptr = 0;
        for (int c = 2; c <= lat && !aborted; c++) begin
            if (c == rst_at) begin
                rst = 1'b0;
                reset_model();
                aborted = 1'b1;
            end else begin
                if (inject && c == 2) begin
                    g_load_a = 1'b1; g_start = 1'b1; g_din = 16'h5A5A;
                end
                tick();
                g_load_a = 1'b0; g_start = 1'b0;
                exp_done = (c == lat);
            end
        end
        if (aborted) begin
            tick();
            rst = 1'b1;
            tick();
        end else begin
            m_r = model_op(md, m_a, m_b, m_p);
            tick();
            exp_busy = 1'b0; exp_done = 1'b0;
        end
    endtask

    // Unload cnt words; returns the first NW words assembled LSB first
    task automatic unload_n(input int cnt, output logic [255:0] got);
        got = 256'd0;
        for (int k = 0; k < cnt; k++) begin
            g_unload = 1'b1;
            tick();
            exp_vld  = 1'b1;
            exp_dout = 16'(m_r >> (exp_ptr * dw_f())) & mask_f();
            if (k < nw_f()) got = got | (256'(g_dout & mask_f()) << (k * dw_f()));
            exp_ptr = (exp_ptr + 1) % nw_f();
        end
        g_unload = 1'b0;
        tick();
        exp_vld = 1'b0;
    endtask

    // Per-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", 256'(g_busy), 256'(exp_busy));
            check("done", 256'(g_done), 256'(exp_done));
            check("err", 256'(g_err), 256'(exp_err));
            check("dout_vld", 256'(g_vld), 256'(exp_vld));
            check("dout", 256'(g_dout), 256'(exp_dout));
        end
    end

    initial begin
        logic [255:0] got;
        logic [255:0] ra, rb;
        rst = 1'b0; sel = 1'b0; g_din = 16'h0000; g_mode = 2'b00;
        g_load_a = 1'b0; g_load_b = 1'b0; g_load_p = 1'b0; g_start = 1'b0; g_unload = 1'b0;
        chk_en = 1'b0;
        reset_model();
        #1 chk_en = 1'b1;
        tick();
        check("rst_dout", 256'(g_dout), 256'd0);
        check("rst_busy", 256'(g_busy), 256'd0);
        tick();
        rst = 1'b1;
        tick();

        // 1: mul, done 9 cycles after start, words 0xA, 0xD, then wrap to 0xA
        load_op(3'b001, 256'h35);
        load_op(3'b010, 256'h2A);
        load_op(3'b100, 256'hFB);
        run_op(2'b00, 1'b0, 1'b0, 0);
        check("t1_model", m_r, 256'hDA);
        unload_n(3, got);
        check("t1_mul", got, 256'hDA);
        check("t1_wrap", 256'(g_dout), 256'h0A);

        // 2: add (start together with unload: start wins), then add with wrap through P
        run_op(2'b01, 1'b1, 1'b0, 0);
        unload_n(2, got);
        check("t2_add", got, 256'h5F);
        load_op(3'b001, 256'hF0);
        load_op(3'b010, 256'h20);
        run_op(2'b01, 1'b0, 1'b0, 0);
        unload_n(2, got);
        check("t2_add_wrap", got, 256'h15);

        // 3: sub with borrow; B is loaded with load_a also high (load_b wins)
        load_op(3'b001, 256'h2A);
        load_op(3'b011, 256'h35);
        run_op(2'b10, 1'b0, 1'b0, 0);
        unload_n(2, got);
        check("t3_sub", got, 256'hF0);

        // 4: P==0 error, reserved mode error, then a valid start clears err
        load_op(3'b100, 256'h00);
        run_op(2'b00, 1'b0, 1'b0, 0);
        check("t4_err", 256'(g_err), 256'd1);
        unload_n(2, got);
        check("t4_r_zero", got, 256'd0);
        load_op(3'b100, 256'hFB);
        run_op(2'b11, 1'b0, 1'b0, 0);
        check("t4_err_rsvd", 256'(g_err), 256'd1);
        run_op(2'b01, 1'b0, 1'b0, 0);
        check("t4_err_clr", 256'(g_err), 256'd0);
        unload_n(2, got);
        check("t4_add", got, 256'h5F);

        // 5: load/start while busy ignored; reset mid-RUN aborts; rerun
        load_op(3'b001, 256'h35);
        load_op(3'b010, 256'h2A);
        run_op(2'b00, 1'b0, 1'b1, 0);
        unload_n(2, got);
        check("t5_inject", got, 256'hDA);
        run_op(2'b00, 1'b0, 1'b0, 4);
        check("t5_busy", 256'(g_busy), 256'd0);
        check("t5_done", 256'(g_done), 256'd0);
        unload_n(2, got);
        check("t5_r_zero", got, 256'd0);
        load_op(3'b001, 256'h35);
        load_op(3'b010, 256'h2A);
        load_op(3'b100, 256'hFB);
        run_op(2'b00, 1'b0, 1'b0, 0);
        unload_n(2, got);
        check("t5_rerun", got, 256'hDA);

        // 6: default parameters, SM2 prime, random operands across all modes
        reset_pulse();
        sel = 1'b1;
        tick();
        load_op(3'b100, SM2_P);
        for (int i = 0; i < 200; i++) begin
            ra = rand_below(SM2_P);
            rb = rand_below(SM2_P);
            load_op(3'b001, ra);
            load_op(3'b010, rb);
            run_op(2'(i % 3), 1'b0, (i % 25) == 0, 0);
            unload_n(16, got);
            check("t6_rand", got, m_r);
        end

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
